mem_access_stage: RTL
=====================

// Module: mem_access_stage
// PURPOSE
//  MEM stage plus MEM/WB pipeline register of the 5-stage MIPS pipeline; consumes the EX/MEM register outputs.
//  Performs byte/half/word stores and loads to a synchronous data RAM with sign/zero extension and alignment checks.
//  Registers everything the WB stage needs: load data, ALU result, destination, control, cs and PC.
// PARAMETERS
//  ADDR_W   10   word-address width; RAM depth = 2**ADDR_W words (4 KB at default)
// PORTS
//  Clk              in   1    rising-edge clock
//  Rst_n            in   1    asynchronous, active-low reset
//  Mem_alu_result   in   32   effective address / ALU result
//  Mem_busB         in   32   store data
//  Mem_busA         in   32   forwarded rs value, passed through
//  Mem_Rw           in   5    destination register
//  Mem_RegWr        in   1    register write enable
//  Mem_MemtoReg     in   1    1 = WB selects load data
//  Mem_MemWr        in   2    store size: 00 none, 01 byte, 10 half, 11 word
//  Mem_MemRead      in   2    load size: 00 none, 01 byte, 10 half, 11 word
//  Mem_LoadUnsigned in   1    1 = zero-extend loads (lbu/lhu)
//  Mem_cs           in   5    cause/status code, passed through
//  Mem_PC           in   30   PC[31:2], passed through
//  Flush            in   1    squash instruction in MEM (exception/redirect)
//  Wr_Dout          out  32   extended load data
//  Wr_alu_result    out  32   registered Mem_alu_result
//  Wr_busA          out  32   registered Mem_busA
//  Wr_Rw            out  5    registered destination
//  Wr_RegWr         out  1    registered write enable (gated)
//  Wr_MemtoReg      out  1    registered MemtoReg
//  Wr_cs            out  5    registered cs
//  Wr_PC            out  30   registered PC[31:2]
//  Wr_AdEL          out  1    misaligned load detected
//  Wr_AdES          out  1    misaligned store detected
// BEHAVIOUR
//  - Reset: Rst_n low clears every Wr_* output to 0 immediately; RAM contents not reset; RAM writes blocked while Rst_n low.
//  - Latency: 1 cycle. All Wr_* update on the Clk edge that ends the MEM cycle; RAM read is synchronous on that same edge.
//  - Address: word index = alu_result[ADDR_W+1:2]; upper bits ignored (aliasing wrap, 0x1000 == 0x0 at default).
//  - Little-endian lanes: byte k = bits [8k+7:8k], k = addr[1:0]; half uses lanes {addr[1],0} and {addr[1],1}.
//  - Store byte writes busB[7:0] to lane k; half writes busB[15:0] to lanes of addr[1]; word writes all four. Other lanes untouched.
//  - Alignment: half needs addr[0]=0; word needs addr[1:0]=00. Violation on store -> no RAM write, Wr_AdES=1.
//    Violation on load -> Wr_AdEL=1, Wr_RegWr=0. Byte accesses never misaligned.
//  - Load extraction selects lane(s) by addr and extends by Mem_LoadUnsigned; word loads unextended. MemRead=00 -> Wr_Dout=0.
//  - Read/write same cycle cannot occur (one instruction); store at edge N then load same word sees new data (write-first not needed).
//  - MemWr and MemRead both nonzero: illegal; store wins, Wr_Dout=0.
//  - Flush=1: RAM write suppressed, next edge loads a bubble: Wr_RegWr=0, Wr_MemtoReg=0, Wr_AdEL=Wr_AdES=0, others don't care (driven 0).
//  - Wr_RegWr = Mem_RegWr & ~Flush & ~AdEL-condition.
//  - Reset released mid-stream: first edge after release captures current inputs normally.
// TESTING
//  1 Reset: Rst_n=0 async mid-cycle -> all Wr_* = 0 before next edge; store presented during reset leaves RAM unchanged.
//  2 sw 0xDEADBEEF @0x10, then lw @0x10 -> Wr_Dout=0xDEADBEEF, Wr_MemtoReg=1, Wr_RegWr=1.
//  3 sb 0x80 @0x21, lb @0x21 -> 0xFFFFFF80; lbu -> 0x00000080; lw @0x20 shows only byte1 changed.
//  4 sh @0x31 -> Wr_AdES=1, RAM word @0x30 unchanged; lw @0x22 -> Wr_AdEL=1, Wr_RegWr=0.
//  5 sw 0x12345678 @0x1004 (ADDR_W=10) then lw @0x4 -> 0x12345678 (wrap alias).
//  6 sw with Flush=1 -> RAM unchanged, Wr_RegWr=0; back-to-back sw/lw/lhu sequence with pass-through Rw/cs/PC checked each cycle.

Source files
------------

// File: rtl/mem_access_stage.sv
// MIPS MEM stage with MEM/WB pipeline register: byte/half/word stores and loads to a
// synchronous data RAM, with alignment exceptions, load extension and WB pass-through.
module mem_access_stage #(
    parameter int unsigned ADDR_W = 10
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic [31:0] Mem_alu_result,
    input  logic [31:0] Mem_busB,
    input  logic [31:0] Mem_busA,
    input  logic [4:0]  Mem_Rw,
    input  logic        Mem_RegWr,
    input  logic        Mem_MemtoReg,
    input  logic [1:0]  Mem_MemWr,
    input  logic [1:0]  Mem_MemRead,
    input  logic        Mem_LoadUnsigned,
    input  logic [4:0]  Mem_cs,
    input  logic [29:0] Mem_PC,
    input  logic        Flush,
    output logic [31:0] Wr_Dout,
    output logic [31:0] Wr_alu_result,
    output logic [31:0] Wr_busA,
    output logic [4:0]  Wr_Rw,
    output logic        Wr_RegWr,
    output logic        Wr_MemtoReg,
    output logic [4:0]  Wr_cs,
    output logic [29:0] Wr_PC,
    output logic        Wr_AdEL,
    output logic        Wr_AdES
);

    localparam int unsigned Depth = 2 ** ADDR_W;

    localparam logic [1:0] SizeNone = 2'b00;
    localparam logic [1:0] SizeByte = 2'b01;
    localparam logic [1:0] SizeHalf = 2'b10;
    localparam logic [1:0] SizeWord = 2'b11;

    logic [31:0]       mem [Depth];
    logic [ADDR_W-1:0] word_idx;
    logic [1:0]        addr_lo;

    logic              store_act;
    logic              store_misal;
    logic              load_act;
    logic              load_misal;
    logic              wr_en;
    logic [3:0]        byte_en;
    logic [31:0]       wr_data;

    logic [31:0]       rdata_q;
    logic [1:0]        rd_size_d, rd_size_q;
    logic [1:0]        rd_lane_q;
    logic              rd_uns_q;

    logic [31:0]       lane_word;
    logic [31:0]       half_word;

    // Upper address bits are ignored so the RAM aliases across the 32-bit space.
    assign word_idx = Mem_alu_result[ADDR_W+1:2];
    assign addr_lo  = Mem_alu_result[1:0];

    always_comb begin
        store_act   = (Mem_MemWr != SizeNone);
        store_misal = ((Mem_MemWr == SizeHalf) && addr_lo[0]) ||
                      ((Mem_MemWr == SizeWord) && (addr_lo != 2'b00));
        // A store alongside a load is illegal; the store takes priority.
        load_act    = (Mem_MemRead != SizeNone) && !store_act;
        load_misal  = load_act &&
                      (((Mem_MemRead == SizeHalf) && addr_lo[0]) ||
                       ((Mem_MemRead == SizeWord) && (addr_lo != 2'b00)));
        wr_en       = store_act && !store_misal && !Flush;
        rd_size_d   = (load_act && !load_misal && !Flush) ? Mem_MemRead : SizeNone;
    end

    always_comb begin
        byte_en = 4'b0000;
        wr_data = Mem_busB;
        unique case (Mem_MemWr)
            SizeByte: begin
                byte_en = 4'b0001 << addr_lo;
                wr_data = {4{Mem_busB[7:0]}};
            end
            SizeHalf: begin
                byte_en = addr_lo[1] ? 4'b1100 : 4'b0011;
                wr_data = {2{Mem_busB[15:0]}};
            end
            SizeWord: begin
                byte_en = 4'b1111;
                wr_data = Mem_busB;
            end
            default: begin
                byte_en = 4'b0000;
                wr_data = Mem_busB;
            end
        endcase
    end

    // Data RAM: byte-lane writes and a registered read port, not reset.
    always_ff @(posedge Clk) begin
        if (Rst_n && wr_en) begin
            for (int k = 0; k < 4; k++) begin
                if (byte_en[k]) begin
                    mem[word_idx][8*k +: 8] <= wr_data[8*k +: 8];
                end
            end
        end
        rdata_q <= mem[word_idx];
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            rd_size_q     <= SizeNone;
            rd_lane_q     <= 2'b00;
            rd_uns_q      <= 1'b0;
            Wr_alu_result <= 32'd0;
            Wr_busA       <= 32'd0;
            Wr_Rw         <= 5'd0;
            Wr_RegWr      <= 1'b0;
            Wr_MemtoReg   <= 1'b0;
            Wr_cs         <= 5'd0;
            Wr_PC         <= 30'd0;
            Wr_AdEL       <= 1'b0;
            Wr_AdES       <= 1'b0;
        end else if (Flush) begin
            rd_size_q     <= SizeNone;
            rd_lane_q     <= 2'b00;
            rd_uns_q      <= 1'b0;
            Wr_alu_result <= 32'd0;
            Wr_busA       <= 32'd0;
            Wr_Rw         <= 5'd0;
            Wr_RegWr      <= 1'b0;
            Wr_MemtoReg   <= 1'b0;
            Wr_cs         <= 5'd0;
            Wr_PC         <= 30'd0;
            Wr_AdEL       <= 1'b0;
            Wr_AdES       <= 1'b0;
        end else begin
            rd_size_q     <= rd_size_d;
            rd_lane_q     <= addr_lo;
            rd_uns_q      <= Mem_LoadUnsigned;
            Wr_alu_result <= Mem_alu_result;
            Wr_busA       <= Mem_busA;
            Wr_Rw         <= Mem_Rw;
            Wr_RegWr      <= Mem_RegWr && !load_misal;
            Wr_MemtoReg   <= Mem_MemtoReg;
            Wr_cs         <= Mem_cs;
            Wr_PC         <= Mem_PC;
            Wr_AdEL       <= load_misal;
            Wr_AdES       <= store_misal;
        end
    end

    // Lane extraction runs after the RAM register so the read port stays a plain sync read.
    always_comb begin
        lane_word = rdata_q >> {rd_lane_q, 3'b000};
        half_word = rdata_q >> {rd_lane_q[1], 4'b0000};
        Wr_Dout   = 32'd0;
        unique case (rd_size_q)
            SizeByte: Wr_Dout = rd_uns_q ? {24'd0, lane_word[7:0]}
                                         : {{24{lane_word[7]}}, lane_word[7:0]};
            SizeHalf: Wr_Dout = rd_uns_q ? {16'd0, half_word[15:0]}
                                         : {{16{half_word[15]}}, half_word[15:0]};
            SizeWord: Wr_Dout = rdata_q;
            default:  Wr_Dout = 32'd0;
        endcase
    end

endmodule
